// File: rtl/color_palette.sv
// color_palette: programmable 16-colour palette stage for the VIC pixel path.
// The VIC colour index goes through a banked palette RAM. Blanking and dim are
// applied, and the result arrives as RGB with a data-enable flag two cycles later.
module color_palette #(
   parameter int CHANNEL_BITS = 6,
   parameter int NUM_BANKS    = 2
) (
   input  logic                      clk_dot4x,
   input  logic                      rst_n,
   input  logic [9:0]                x_pos,
   input  logic [8:0]                y_pos,
   input  logic [3:0]                out_pixel,
   input  logic [9:0]                hSyncStart,
   input  logic [9:0]                hVisibleStart,
   input  logic [8:0]                vBlankStart,
   input  logic [8:0]                vBlankEnd,
   input  logic [1:0]                pal_bank,
   input  logic                      dim,
   input  logic                      wr_en,
   input  logic [1:0]                wr_bank,
   input  logic [3:0]                wr_index,
   input  logic [3*CHANNEL_BITS-1:0] wr_data,
   output logic [3*CHANNEL_BITS-1:0] rd_data,
   output logic [CHANNEL_BITS-1:0]   red,
   output logic [CHANNEL_BITS-1:0]   green,
   output logic [CHANNEL_BITS-1:0]   blue,
   output logic                      de
);

   localparam int PW = 3 * CHANNEL_BITS;

   // Widen a 2-bit level by repeating it MSB-first and keeping the top CHANNEL_BITS bits.
   function automatic logic [CHANNEL_BITS-1:0] expand2(input logic [1:0] v);
      logic [17:0] rep;
      rep = {9{v}};
      return rep[17 -: CHANNEL_BITS];
   endfunction

   // Default VIC palette, packed as 2-bit {r,g,b} levels.
   function automatic logic [PW-1:0] default_entry(input logic [3:0] idx);
      logic [5:0] c;
      c = '0;
      case (idx)
         4'd0:  c = 6'b00_00_00; // BLACK
         4'd1:  c = 6'b11_11_11; // WHITE
         4'd2:  c = 6'b10_00_00; // RED
         4'd3:  c = 6'b10_11_11; // CYAN
         4'd4:  c = 6'b11_01_11; // PURPLE
         4'd5:  c = 6'b00_11_01; // GREEN
         4'd6:  c = 6'b00_00_10; // BLUE
         4'd7:  c = 6'b11_11_01; // YELLOW
         4'd8:  c = 6'b11_10_01; // ORANGE
         4'd9:  c = 6'b01_01_00; // BROWN
         4'd10: c = 6'b11_01_01; // PINK
         4'd11: c = 6'b00_00_00; // DARK_GREY
         4'd12: c = 6'b01_01_01; // GREY
         4'd13: c = 6'b10_11_01; // LIGHT_GREEN
         4'd14: c = 6'b00_10_11; // LIGHT_BLUE
         4'd15: c = 6'b10_10_10; // LIGHT_GREY
         default: c = 6'b00_00_00;
      endcase
      return {expand2(c[5:4]), expand2(c[3:2]), expand2(c[1:0])};
   endfunction

   logic [PW-1:0]           r_pal [NUM_BANKS][16];
   logic [3:0]              r_s1_index;
   logic [1:0]              r_s1_bank;
   logic                    r_s1_vis;
   logic                    r_s1_dim;
   logic [PW-1:0]           r_s2_rgb;
   logic                    r_s2_de;
   logic [PW-1:0]           r_rd_data;

   logic                    w_visible;
   logic [1:0]              w_bank;
   logic [PW-1:0]           w_lookup;
   logic [PW-1:0]           w_rd;
   logic [CHANNEL_BITS-1:0] w_r;
   logic [CHANNEL_BITS-1:0] w_g;
   logic [CHANNEL_BITS-1:0] w_b;

   // Raster window test; an exact match with any bound counts as blanked.
   assign w_visible = ((x_pos < hSyncStart) || (x_pos > hVisibleStart)) &&
                      ((y_pos < vBlankStart) || (y_pos > vBlankEnd));
   assign w_bank    = (int'(pal_bank) < NUM_BANKS) ? pal_bank : 2'd0;

   // Palette RAM: reset to defaults, and a write to a bank that does not exist is ignored.
   // NOTE: the palette is reset on purpose, so every bank holds the defaults after reset. This rules out a RAM macro, and at 16 entries per bank flops are the right choice anyway.
   always_ff @(posedge clk_dot4x or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++)
            for (int i = 0; i < 16; i++)
               r_pal[b][i] <= default_entry(4'(i));
      end else if (wr_en) begin
         for (int b = 0; b < NUM_BANKS; b++)
            if (wr_bank == 2'(b)) r_pal[b][wr_index] <= wr_data;
      end
   end

   // Bank select muxes for the S2 lookup and for the readback port.
   // NOTE: each output gets a default before the loop, so no path leaves it unassigned and no latch can form.
   always_comb begin
      w_lookup = '0;
      w_rd     = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (r_s1_bank == 2'(b)) w_lookup = r_pal[b][r_s1_index];
         if (wr_bank == 2'(b))   w_rd     = r_pal[b][wr_index];
      end
   end

   // Dim halves each channel with a logical shift.
   always_comb begin
      w_r = w_lookup[PW-1 -: CHANNEL_BITS];
      w_g = w_lookup[2*CHANNEL_BITS-1 -: CHANNEL_BITS];
      w_b = w_lookup[CHANNEL_BITS-1:0];
      if (r_s1_dim) begin
         w_r = w_r >> 1;
         w_g = w_g >> 1;
         w_b = w_b >> 1;
      end
   end

   // S1 captures the index, bank, visibility and dim. S2 captures the blanked colour.
   // The S2 lookup reads the palette at the same edge as a concurrent write, so it sees pre-write data.
   // NOTE: every state update uses <= so that all registers sample pre-edge values, which is what gives the collision behaviour above.
   always_ff @(posedge clk_dot4x or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_index <= '0;
         r_s1_bank  <= '0;
         r_s1_vis   <= 1'b0;
         r_s1_dim   <= 1'b0;
         r_s2_rgb   <= '0;
         r_s2_de    <= 1'b0;
      end else begin
         r_s1_index <= out_pixel;
         r_s1_bank  <= w_bank;
         r_s1_vis   <= w_visible;
         r_s1_dim   <= dim;
         r_s2_rgb   <= r_s1_vis ? {w_r, w_g, w_b} : '0;
         r_s2_de    <= r_s1_vis;
      end
   end

   // Readback register: shows the entry addressed by wr_bank and wr_index as it was before this edge.
   always_ff @(posedge clk_dot4x or negedge rst_n) begin
      if (!rst_n) r_rd_data <= '0;
      else        r_rd_data <= w_rd;
   end

   assign red     = r_s2_rgb[PW-1 -: CHANNEL_BITS];
   assign green   = r_s2_rgb[2*CHANNEL_BITS-1 -: CHANNEL_BITS];
   assign blue    = r_s2_rgb[CHANNEL_BITS-1:0];
   assign de      = r_s2_de;
   assign rd_data = r_rd_data;

endmodule

// File: tb/tb_color_palette.sv
// tb_color_palette: directed-vector bench for color_palette with CHANNEL_BITS=6 and NUM_BANKS=2.
module tb_color_palette;

   logic        clk_dot4x;
   logic        rst_n;
   logic [9:0]  x_pos;
   logic [8:0]  y_pos;
   logic [3:0]  out_pixel;
   logic [9:0]  hSyncStart;
   logic [9:0]  hVisibleStart;
   logic [8:0]  vBlankStart;
   logic [8:0]  vBlankEnd;
   logic [1:0]  pal_bank;
   logic        dim;
   logic        wr_en;
   logic [1:0]  wr_bank;
   logic [3:0]  wr_index;
   logic [17:0] wr_data;
   logic [17:0] rd_data;
   logic [5:0]  red;
   logic [5:0]  green;
   logic [5:0]  blue;
   logic        de;

   int n_checks = 0;
   int n_errors = 0;

   color_palette #(.CHANNEL_BITS(6), .NUM_BANKS(2)) dut (
      .clk_dot4x    (clk_dot4x),
      .rst_n        (rst_n),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .out_pixel    (out_pixel),
      .hSyncStart   (hSyncStart),
      .hVisibleStart(hVisibleStart),
      .vBlankStart  (vBlankStart),
      .vBlankEnd    (vBlankEnd),
      .pal_bank     (pal_bank),
      .dim          (dim),
      .wr_en        (wr_en),
      .wr_bank      (wr_bank),
      .wr_index     (wr_index),
      .wr_data      (wr_data),
      .rd_data      (rd_data),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .de           (de)
   );

   initial clk_dot4x = 1'b0;
   always #5 clk_dot4x = ~clk_dot4x;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Expected pixel word {de, r, g, b}.
   function automatic logic [31:0] px(input logic e, input logic [5:0] r, input logic [5:0] g,
                                      input logic [5:0] b);
      return {13'd0, e, r, g, b};
   endfunction

   function automatic logic [31:0] obs();
      return {13'd0, de, red, green, blue};
   endfunction

   task automatic tick();
      @(posedge clk_dot4x);
      #1;
   endtask

   task automatic set_px(input logic [9:0] x, input logic [8:0] y, input logic [3:0] idx,
                         input logic [1:0] bank, input logic dm);
      x_pos = x; y_pos = y; out_pixel = idx; pal_bank = bank; dim = dm;
   endtask

   // Present one pixel and check it after the two-cycle latency.
   task automatic run_px(input string tag, input logic [9:0] x, input logic [8:0] y,
                         input logic [3:0] idx, input logic [1:0] bank, input logic dm,
                         input logic [31:0] exp);
      set_px(x, y, idx, bank, dm);
      tick();
      tick();
      check(tag, obs(), exp);
   endtask

   task automatic write_entry(input logic [1:0] bank, input logic [3:0] idx, input logic [17:0] data);
      wr_en = 1'b1; wr_bank = bank; wr_index = idx; wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      hSyncStart = 10'd400; hVisibleStart = 10'd500;
      vBlankStart = 9'd250; vBlankEnd = 9'd280;
      set_px(10'd100, 9'd100, 4'd1, 2'd0, 1'b0);
      wr_en = 1'b0; wr_bank = 2'd0; wr_index = 4'd0; wr_data = '0;
      #12;
      check("reset_pixel", obs(), px(0, 6'h00, 6'h00, 6'h00));
      check("reset_rd_data", 32'(rd_data), 32'd0);
      tick();
      rst_n = 1'b1;

      // Default palette: stream WHITE and then CYAN back to back.
      set_px(10'd100, 9'd100, 4'd1, 2'd0, 1'b0);
      tick();
      set_px(10'd100, 9'd100, 4'd3, 2'd0, 1'b0);
      tick();
      check("default_white", obs(), px(1, 6'h3F, 6'h3F, 6'h3F));
      tick();
      check("default_cyan", obs(), px(1, 6'h2A, 6'h3F, 6'h3F));

      // Blanking window bounds.
      run_px("blank_x_eq_hsync", 10'd400, 9'd100, 4'd1, 2'd0, 1'b0, px(0, 0, 0, 0));
      run_px("blank_y_eq_vend", 10'd100, 9'd280, 4'd1, 2'd0, 1'b0, px(0, 0, 0, 0));
      run_px("blank_x_eq_hvis", 10'd500, 9'd100, 4'd1, 2'd0, 1'b0, px(0, 0, 0, 0));
      run_px("blank_y_eq_vstart", 10'd100, 9'd250, 4'd1, 2'd0, 1'b0, px(0, 0, 0, 0));
      run_px("vis_x_hsync_m1", 10'd399, 9'd100, 4'd1, 2'd0, 1'b0, px(1, 6'h3F, 6'h3F, 6'h3F));
      run_px("vis_x_hvis_p1", 10'd501, 9'd281, 4'd1, 2'd0, 1'b0, px(1, 6'h3F, 6'h3F, 6'h3F));

      // Write bank 1 entry RED, then check readback across the write edge.
      write_entry(2'd1, 4'd2, {6'h3F, 6'h00, 6'h3F});
      check("rd_old_on_write", 32'(rd_data), 32'({6'h2A, 6'h00, 6'h00}));
      tick();
      check("rd_new_after_write", 32'(rd_data), 32'({6'h3F, 6'h00, 6'h3F}));
      run_px("bank1_red", 10'd100, 9'd100, 4'd2, 2'd1, 1'b0, px(1, 6'h3F, 6'h00, 6'h3F));
      run_px("bank0_red", 10'd100, 9'd100, 4'd2, 2'd0, 1'b0, px(1, 6'h2A, 6'h00, 6'h00));

      // Collision: write bank0 BLUE at the edge where a BLUE pixel moves into S2.
      set_px(10'd100, 9'd100, 4'd6, 2'd0, 1'b0);
      tick();
      write_entry(2'd0, 4'd6, {6'h15, 6'h15, 6'h15});
      check("collision_old_pixel", obs(), px(1, 6'h00, 6'h00, 6'h2A));
      check("collision_rd_old", 32'(rd_data), 32'({6'h00, 6'h00, 6'h2A}));
      tick();
      check("collision_new_pixel", obs(), px(1, 6'h15, 6'h15, 6'h15));
      check("collision_rd_new", 32'(rd_data), 32'({6'h15, 6'h15, 6'h15}));

      // Dim and out-of-range banks.
      run_px("dim_yellow", 10'd100, 9'd100, 4'd7, 2'd0, 1'b1, px(1, 6'h1F, 6'h1F, 6'h0A));
      run_px("dim_blanked", 10'd400, 9'd100, 4'd7, 2'd0, 1'b1, px(0, 0, 0, 0));
      run_px("bank3_is_bank0", 10'd100, 9'd100, 4'd2, 2'd3, 1'b0, px(1, 6'h2A, 6'h00, 6'h00));
      run_px("bank2_is_bank0", 10'd100, 9'd100, 4'd2, 2'd2, 1'b0, px(1, 6'h2A, 6'h00, 6'h00));
      write_entry(2'd3, 4'd0, 18'h3FFFF);
      tick();
      check("rd_bad_bank_zero", 32'(rd_data), 32'd0);
      run_px("bad_bank_write_b0", 10'd100, 9'd100, 4'd0, 2'd3, 1'b0, px(1, 0, 0, 0));
      run_px("bad_bank_write_b1", 10'd100, 9'd100, 4'd0, 2'd1, 1'b0, px(1, 0, 0, 0));

      // Mid-frame reset while a WHITE pixel is on the outputs.
      run_px("pre_reset_white", 10'd100, 9'd100, 4'd1, 2'd0, 1'b0, px(1, 6'h3F, 6'h3F, 6'h3F));
      wr_bank = 2'd1; wr_index = 4'd2;
      #2 rst_n = 1'b0;
      #1;
      check("midreset_pixel", obs(), px(0, 0, 0, 0));
      check("midreset_rd_data", 32'(rd_data), 32'd0);
      tick();
      rst_n = 1'b1;
      run_px("restored_b1_red", 10'd100, 9'd100, 4'd2, 2'd1, 1'b0, px(1, 6'h2A, 6'h00, 6'h00));
      run_px("restored_b0_blue", 10'd100, 9'd100, 4'd6, 2'd0, 1'b0, px(1, 6'h00, 6'h00, 6'h2A));
      check("restored_rd_b1_red", 32'(rd_data), 32'({6'h2A, 6'h00, 6'h00}));
      run_px("restored_grey", 10'd100, 9'd100, 4'd12, 2'd1, 1'b0, px(1, 6'h15, 6'h15, 6'h15));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/color_palette.md
# color_palette

Registered, programmable palette stage that converts the 4-bit VIC colour index into RGB output of parameterised depth. It sits between the pixel sequencer and the video DAC/scaler. It holds NUM_BANKS writable 16-entry palettes, applies horizontal and vertical blanking and an optional dim mode, and delivers a fixed two-cycle pipelined result with a matching data-enable flag.

## Interface
- CHANNEL_BITS, default 6: width of each of red, green and blue; legal range 2..8.
- NUM_BANKS, default 2: number of 16-entry palettes; legal range 1..4.
- clk_dot4x  in  1  pixel-pipeline clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- x_pos  in  10  raster x of the current pixel.
- y_pos  in  9  raster y of the current pixel.
- out_pixel  in  4  colour index; vic_color encoding, BLACK=0 .. LIGHT_GREY=15.
- hSyncStart  in  10  blanking-window x bound.
- hVisibleStart  in  10  blanking-window x bound.
- vBlankStart  in  9  blanking-window y bound.
- vBlankEnd  in  9  blanking-window y bound.
- pal_bank  in  2  bank used for lookup.
- dim  in  1  halves all three channels of the lookup result.
- wr_en  in  1  palette write strobe, one cycle per write.
- wr_bank  in  2  bank to write.
- wr_index  in  4  entry to write.
- wr_data  in  3*CHANNEL_BITS  new entry value, packed {r,g,b}.
- rd_data  out  3*CHANNEL_BITS  registered readback of entry [wr_bank][wr_index].
- red, green, blue  out  CHANNEL_BITS each  pixel colour.
- de  out  1  visible flag, aligned with red, green and blue.

## Operation
- **Visibility.** visible = (x_pos < hSyncStart || x_pos > hVisibleStart) && (y_pos < vBlankStart || y_pos > vBlankEnd).
  - Comparisons are unsigned.
  - Equality with a bound counts as blanked.
- **Default palette.** Loaded into every bank on reset. Each entry is given as 2-bit r,g,b:
  - BLACK 0,0,0; WHITE 3,3,3; RED 2,0,0; CYAN 2,3,3
  - PURPLE 3,1,3; GREEN 0,3,1; BLUE 0,0,2; YELLOW 3,3,1
  - ORANGE 3,2,1; BROWN 1,1,0; PINK 3,1,1; DARK_GREY 0,0,0
  - GREY 1,1,1; LIGHT_GREEN 2,3,1; LIGHT_BLUE 0,2,3; LIGHT_GREY 2,2,2
- **Default expansion.** Each 2-bit value v becomes CHANNEL_BITS wide by repeating v MSB-first and truncating to CHANNEL_BITS.
  - 6 bits: 3→111111, 2→101010, 1→010101.
  - 3 bits: 2→101.
- **Writes.**
  - With wr_en=1 and wr_bank < NUM_BANKS, entry [wr_bank][wr_index] takes wr_data at the edge.
  - wr_bank ≥ NUM_BANKS: the write is ignored.
- **Readback.** rd_data updates every cycle with the pre-write contents of [wr_bank][wr_index]. It reads 0 when wr_bank ≥ NUM_BANKS.
- **Lookup bank.** pal_bank ≥ NUM_BANKS selects bank 0.
- **Dim.** When set, each channel is shifted right by 1 (logical), so 6-bit 111111 becomes 011111. Dim applies only to visible pixels.
- **Blanked pixels.** red = green = blue = 0 and de = 0, whatever the palette contents or dim.
- There is no state machine. The block has a palette RAM (NUM_BANKS×16×3·CHANNEL_BITS registers) and a two-stage pipeline:
  - S1 registers index, bank, visible and dim.
  - S2 registers the looked-up, dimmed and blanked colour, plus de.

## Timing
- **Latency.** Inputs sampled at edge N appear on red, green, blue and de after edge N+1, i.e. 2 cycles.
- **Throughput.** One pixel per clock, no stalls.
- **Write/lookup collision.** A write at edge N is seen by a lookup whose S1 stage registers at edge N or later, i.e. inputs presented at edge N or later.
  - A pixel already in S1 at edge N, i.e. presented at edge N−1, returns the old value.
  - This means the S2 read takes place at edge N concurrently with the write and uses pre-write data.
- **Readback.** rd_data appears one cycle after wr_bank/wr_index are presented. On the write edge it shows the old value; the next cycle it shows the new one.
- **Reset.** rst_n low asynchronously forces:
  - red, green, blue, de and rd_data to 0;
  - the pipeline registers to 0 (blanked);
  - every bank to the default palette.
- **Reset release.** Writes issued while rst_n is low are lost. The first valid pixel appears 2 cycles after rst_n rises.
- **Mid-frame reset.** Takes effect immediately. No partial pixel is emitted.

## Test plan
- **Default palette.** Reset, CHANNEL_BITS=6, visible raster, out_pixel=WHITE then CYAN → two cycles later RGB = 3F,3F,3F then 2A,3F,3F with de=1.
- **Blanking.** x_pos = hSyncStart, then y_pos = vBlankEnd, each with out_pixel=WHITE → RGB = 0 and de = 0 for both; x_pos = hSyncStart−1 → WHITE.
- **Write bank 1, then look up.** Write bank 1 index 2 = {3F,00,3F}, then look up RED with pal_bank=1 → 3F,00,3F; the same lookup with pal_bank=0 → 2A,00,00.
- **Collision.** Write index 6 in the same cycle a BLUE pixel enters S2 → that pixel gives 00,00,2A. The following BLUE pixel gives the new value. On the write edge rd_data shows the old value.
- **Dim and out-of-range bank.** dim=1 with YELLOW → 1F,1F,0A. pal_bank=3 with NUM_BANKS=2 → bank 0 value. A write with wr_bank=3 → no change.
- **Reset mid-frame.** Reset while streaming after palette writes → outputs 0 at once; after release, defaults are restored in all banks.
